regfile_2r1w: RTL and testbench
===============================

REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter XLEN, default 32, data width of every register and data port.
REQ-002 Parameter AW, default 5, register address width; register count = 2**AW (32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rd_en  input  1  operand read request for the ALU stage.
REQ-006 rs1_addr  input  AW  first source register index.
REQ-007 rs2_addr  input  AW  second source register index.
REQ-008 rs1_data  output  XLEN  registered operand 1, drives ALU rs1.
REQ-009 rs2_data  output  XLEN  registered operand 2, drives ALU rs2.
REQ-010 rd_valid  output  1  rs1_data/rs2_data hold the result of a read issued on the previous edge.
REQ-011 rs1_busy  output  1  registered pending-write flag for rs1_addr.
REQ-012 rs2_busy  output  1  registered pending-write flag for rs2_addr.
REQ-013 wr_en  input  1  writeback strobe, carries ALU rd result.
REQ-014 wr_addr  input  AW  writeback destination index.
REQ-015 wr_data  input  XLEN  writeback value.
REQ-016 busy_set  input  1  mark register busy_addr as awaiting a writeback.
REQ-017 busy_addr  input  AW  register index for busy_set.

Function
REQ-018 Storage: 2**AW x XLEN registers plus 2**AW busy bits; register 0 SHALL read as 0 at all times.
REQ-019 Write: on an edge with rst_n=1, wr_en=1, wr_addr!=0, the register SHALL take wr_data; writes to index 0 are discarded.
REQ-020 Read latency: on an edge with rd_en=1, rs1_data/rs2_data SHALL be loaded and rd_valid SHALL be 1 for the following cycle.
REQ-021 On an edge with rd_en=0, rs1_data/rs2_data/rs1_busy/rs2_busy SHALL hold their values and rd_valid SHALL become 0.
REQ-022 Bypass: if wr_en=1 and wr_addr==rsN_addr!=0 on the read edge, rsN_data SHALL load wr_data, not the stale register value.
REQ-023 rs1_addr==rs2_addr SHALL return identical data and busy values on both ports.
REQ-024 Busy clear: on an edge with wr_en=1, busy bit [wr_addr] SHALL be cleared.
REQ-025 Busy set: on an edge with busy_set=1, busy bit [busy_addr] SHALL be set; busy_set with busy_addr=0 is ignored.
REQ-026 Simultaneous busy_set and wr_en to the same nonzero index SHALL leave the bit set (new producer wins); the data write still occurs.
REQ-027 rsN_busy loaded on a read edge SHALL equal the busy bit's next-state value for rsN_addr per REQ-024..026; index 0 SHALL always report 0.
REQ-028 Writes and busy updates SHALL proceed independently of rd_en.

Reset
REQ-029 On an edge with rst_n=0: all registers, all busy bits, rs1_data, rs2_data, rs1_busy, rs2_busy, rd_valid SHALL become 0.
REQ-030 Reset SHALL dominate every simultaneous wr_en, busy_set and rd_en; no write or set takes effect on that edge.
REQ-031 Reset mid-operation SHALL discard pending busy state; the first post-reset read of any index SHALL return data 0, busy 0.

Verification
REQ-032 Reset, then write x5=0x0000_0007, x6=0xFFFF_FFF9 on consecutive edges, then read rs1=5, rs2=6 -> next cycle rs1_data=7, rs2_data=0xFFFF_FFF9, rd_valid=1.
REQ-033 wr_en, wr_addr=0, wr_data=0xDEAD_BEEF, then read rs1=0, rs2=0 -> both data 0, busy 0.
REQ-034 Same edge: wr_en x9=0x1234_5678, rd_en rs1=9, rs2=9 -> next cycle both outputs 0x1234_5678 (bypass).
REQ-035 busy_set x3; read rs1=3 -> rs1_busy=1; wr_en x3=42 with busy_set x3 same edge -> bit stays 1; wr_en x3 alone, then read -> rs1_busy=0, rs1_data=42.
REQ-036 Load x10=100, busy_set x10, then rst_n=0 for one edge with wr_en x10=55 -> read rs1=10 -> rs1_data=0, rs1_busy=0, rd_valid=1.
REQ-037 rd_en=1 one edge then rd_en=0 while writing the read index -> rd_valid drops to 0, rs1_data holds the earlier value.

Source files
------------

// File: rtl/regfile_2r1w.sv
// Two-read / one-write integer register file feeding the ALU stage.
// Holds 2**AW general registers (index 0 hard-wired to zero) and one
// scoreboard busy bit per register. Both read ports are registered, carry
// a write-to-read bypass, and report the busy bit as it will look after
// the current edge so a consumer sees producer/writeback updates at once.
module regfile_2r1w #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rd_valid,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_addr
);

  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;

  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic            r_rs1_busy;
  logic            r_rs2_busy;
  logic            r_rd_valid;

  logic            w_wr_live;
  logic            w_set_live;
  logic [NREG-1:0] w_busy_next;
  logic [XLEN-1:0] w_rs1_next;
  logic [XLEN-1:0] w_rs2_next;
  logic            w_rs1_busy_next;
  logic            w_rs2_busy_next;

  // Writes and busy sets aimed at index 0 never change anything.
  assign w_wr_live  = wr_en && (wr_addr != '0);
  assign w_set_live = busy_set && (busy_addr != '0);

  // Next busy vector: writeback clears first, then a new producer sets, so
  // a same-edge set on the written index leaves the bit set.
  always_comb begin
    w_busy_next = r_busy;
    if (wr_en) begin
      w_busy_next[wr_addr] = 1'b0;
    end
    if (w_set_live) begin
      w_busy_next[busy_addr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Port 1 operand: zero for x0, bypassed writeback value on a matching
  // write, otherwise the stored register.
  always_comb begin
    w_rs1_next = r_regs[rs1_addr];
    if (rs1_addr == '0) begin
      w_rs1_next = '0;
    end else if (w_wr_live && (wr_addr == rs1_addr)) begin
      w_rs1_next = wr_data;
    end
    w_rs1_busy_next = w_busy_next[rs1_addr];
  end

  // Port 2 operand, same selection rules as port 1.
  always_comb begin
    w_rs2_next = r_regs[rs2_addr];
    if (rs2_addr == '0) begin
      w_rs2_next = '0;
    end else if (w_wr_live && (wr_addr == rs2_addr)) begin
      w_rs2_next = wr_data;
    end
    w_rs2_busy_next = w_busy_next[rs2_addr];
  end

  // Register storage: cleared by reset, updated by any nonzero-index write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Busy scoreboard: reset drops every pending producer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Registered read ports: load on rd_en, otherwise hold data and busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rs1_busy <= 1'b0;
      r_rs2_busy <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rs1_data <= w_rs1_next;
        r_rs2_data <= w_rs2_next;
        r_rs1_busy <= w_rs1_busy_next;
        r_rs2_busy <= w_rs2_busy_next;
      end
    end
  end

  assign rs1_data = r_rs1_data;
  assign rs2_data = r_rs2_data;
  assign rs1_busy = r_rs1_busy;
  assign rs2_busy = r_rs2_busy;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Testbench for regfile_2r1w: directed vector table, a reset-discard
// sequence, then randomized traffic against an array-based reference model.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rd_valid;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy_set;
  logic [4:0]  busy_addr;

  int checks;
  int fails;

  regfile_2r1w #(.XLEN(32), .AW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_valid (rd_valid),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy_set (busy_set),
    .busy_addr(busy_addr)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstN;
    logic        rdEn;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wrEn;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        bs;
    logic [4:0]  ba;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ev;
    logic        eb1;
    logic        eb2;
  } vec_t;

  vec_t vecs[$];

  // Reference model: register contents, pending-producer flags, and the
  // values the read ports should present after the latest edge.
  logic [31:0] mMem [32];
  logic        mBusy[32];
  logic [31:0] mRs1;
  logic [31:0] mRs2;
  logic        mValid;
  logic        mB1;
  logic        mB2;

  // Advance the model by one clock edge using the inputs held on that edge.
  task automatic modelStep();
    logic nb[32];
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mMem[i]  = 32'd0;
        mBusy[i] = 1'b0;
      end
      mRs1 = 32'd0; mRs2 = 32'd0; mValid = 1'b0; mB1 = 1'b0; mB2 = 1'b0;
    end else begin
      nb = mBusy;
      if (wr_en) nb[wr_addr] = 1'b0;
      if (busy_set && busy_addr != 5'd0) nb[busy_addr] = 1'b1;
      mValid = rd_en;
      if (rd_en) begin
        if (rs1_addr == 5'd0) mRs1 = 32'd0;
        else if (wr_en && wr_addr == rs1_addr) mRs1 = wr_data;
        else mRs1 = mMem[rs1_addr];
        if (rs2_addr == 5'd0) mRs2 = 32'd0;
        else if (wr_en && wr_addr == rs2_addr) mRs2 = wr_data;
        else mRs2 = mMem[rs2_addr];
        mB1 = (rs1_addr == 5'd0) ? 1'b0 : nb[rs1_addr];
        mB2 = (rs2_addr == 5'd0) ? 1'b0 : nb[rs2_addr];
      end
      if (wr_en && wr_addr != 5'd0) mMem[wr_addr] = wr_data;
      mBusy = nb;
    end
  endtask

  // Drive one edge's worth of inputs, clock it, update the model, settle.
  task automatic applyStimulus(input logic rn, input logic re,
                               input logic [4:0] a1, input logic [4:0] a2,
                               input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic bs,
                               input logic [4:0] ba);
    rst_n = rn; rd_en = re; rs1_addr = a1; rs2_addr = a2;
    wr_en = we; wr_addr = wa; wr_data = wd; busy_set = bs; busy_addr = ba;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOne(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] e1,
                             input logic [31:0] e2, input logic ev,
                             input logic eb1, input logic eb2);
    checkOne({tag, " rs1_data"}, rs1_data, e1);
    checkOne({tag, " rs2_data"}, rs2_data, e2);
    checkOne({tag, " rd_valid"}, {31'd0, rd_valid}, {31'd0, ev});
    checkOne({tag, " rs1_busy"}, {31'd0, rs1_busy}, {31'd0, eb1});
    checkOne({tag, " rs2_busy"}, {31'd0, rs2_busy}, {31'd0, eb2});
  endtask

  task automatic addVec(input logic rn, input logic re, input logic [4:0] a1,
                        input logic [4:0] a2, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic bs, input logic [4:0] ba,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic ev, input logic eb1, input logic eb2);
    vec_t v;
    v.rstN = rn; v.rdEn = re; v.rs1 = a1; v.rs2 = a2; v.wrEn = we;
    v.wa = wa; v.wd = wd; v.bs = bs; v.ba = ba;
    v.e1 = e1; v.e2 = e2; v.ev = ev; v.eb1 = eb1; v.eb2 = eb2;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n = 1'b0; rd_en = 1'b0; rs1_addr = '0; rs2_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; busy_set = 1'b0; busy_addr = '0;

    //     rst rd  rs1 rs2 we wa  wd            bs ba   e1            e2            v  b1 b2
    addVec(0, 1, 5,  6,  1, 5,  32'h0000_0011, 1, 5,  32'h0,        32'h0,        0, 0, 0);
    addVec(1, 1, 5,  0,  0, 0,  32'h0,         0, 0,  32'h0,        32'h0,        1, 0, 0);
    addVec(1, 0, 0,  0,  1, 5,  32'h0000_0007, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    addVec(1, 0, 0,  0,  1, 6,  32'hFFFF_FFF9, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    addVec(1, 1, 5,  6,  0, 0,  32'h0,         0, 0,  32'h0000_0007, 32'hFFFF_FFF9, 1, 0, 0);
    addVec(1, 0, 0,  0,  1, 0,  32'hDEAD_BEEF, 0, 0,  32'h0000_0007, 32'hFFFF_FFF9, 0, 0, 0);
    addVec(1, 1, 0,  0,  0, 0,  32'h0,         0, 0,  32'h0,        32'h0,        1, 0, 0);
    addVec(1, 1, 9,  9,  1, 9,  32'h1234_5678, 0, 0,  32'h1234_5678, 32'h1234_5678, 1, 0, 0);
    addVec(1, 0, 0,  0,  0, 0,  32'h0,         1, 3,  32'h1234_5678, 32'h1234_5678, 0, 0, 0);
    addVec(1, 1, 3,  3,  0, 0,  32'h0,         0, 0,  32'h0,        32'h0,        1, 1, 1);
    addVec(1, 1, 3,  3,  1, 3,  32'd42,        1, 3,  32'd42,       32'd42,       1, 1, 1);
    addVec(1, 0, 0,  0,  1, 3,  32'd42,        0, 0,  32'd42,       32'd42,       0, 1, 1);
    addVec(1, 1, 3,  0,  0, 0,  32'h0,         0, 0,  32'd42,       32'h0,        1, 0, 0);
    addVec(1, 0, 0,  0,  1, 10, 32'd100,       0, 0,  32'd42,       32'h0,        0, 0, 0);
    addVec(1, 0, 0,  0,  0, 0,  32'h0,         1, 10, 32'd42,       32'h0,        0, 0, 0);
    addVec(1, 1, 10, 10, 0, 0,  32'h0,         0, 0,  32'd100,      32'd100,      1, 1, 1);
    addVec(0, 0, 0,  0,  1, 10, 32'd55,        0, 0,  32'h0,        32'h0,        0, 0, 0);
    addVec(1, 1, 10, 10, 0, 0,  32'h0,         0, 0,  32'h0,        32'h0,        1, 0, 0);
    addVec(1, 1, 12, 12, 1, 12, 32'd77,        0, 0,  32'd77,       32'd77,       1, 0, 0);
    addVec(1, 0, 12, 12, 1, 12, 32'd88,        0, 0,  32'd77,       32'd77,       0, 0, 0);
    addVec(1, 1, 12, 12, 0, 0,  32'h0,         0, 0,  32'd88,       32'd88,       1, 0, 0);
    addVec(1, 1, 0,  0,  1, 0,  32'hCAFE_F00D, 1, 0,  32'h0,        32'h0,        1, 0, 0);
    addVec(1, 1, 7,  7,  0, 0,  32'h0,         1, 7,  32'h0,        32'h0,        1, 1, 1);
    addVec(1, 1, 7,  0,  1, 7,  32'd5,         0, 0,  32'd5,        32'h0,        1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].rdEn, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].wrEn, vecs[i].wa, vecs[i].wd, vecs[i].bs, vecs[i].ba);
      checkOutput($sformatf("row%0d", i), vecs[i].e1, vecs[i].e2,
                  vecs[i].ev, vecs[i].eb1, vecs[i].eb2);
    end

    // Fill registers and mark them busy, reset, then every index must read 0/0.
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 5'(i), 32'hA000_0000 + 32'(i), 1, 5'(32 - i));
    end
    applyStimulus(0, 1, 4, 8, 1, 4, 32'h5555_5555, 1, 4);
    checkOutput("midreset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 32; i += 2) begin
      applyStimulus(1, 1, 5'(i), 5'(i + 1), 0, 0, 32'h0, 0, 0);
      checkOutput($sformatf("postreset x%0d", i), 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    end

    // Randomized traffic against the reference model; narrow address range
    // half the time so bypass and busy collisions happen often.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a1, a2, wa, ba;
      logic narrow;
      narrow = 1'($urandom_range(0, 1));
      a1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a2 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ba = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      applyStimulus(($urandom_range(0, 59) != 0), 1'($urandom), a1, a2,
                    1'($urandom), wa, $urandom, 1'($urandom), ba);
      checkOutput($sformatf("rand%0d", n), mRs1, mRs2, mValid, mB1, mB2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
